// File: rtl/fifo_access_scheduler.sv
// Round-robin push arbiter and push/pop serializer in front of a single-port-pair FIFO.
// Keeps its own occupancy count and latches any disagreement with the FIFO flags.
//
// state       | meaning
// last_op = 0 | pop served last (or reset); push wins contention
// last_op = 1 | push served last; pop wins contention
module fifo_access_scheduler #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int NREQ  = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NREQ-1:0]           req_push,
   input  logic [NREQ*WIDTH-1:0]     req_data,
   output logic [NREQ-1:0]           grant_push,
   input  logic                      pop_req,
   output logic                      pop_ack,
   output logic                      fifo_push,
   output logic                      fifo_pop,
   output logic [WIDTH-1:0]          fifo_in,
   input  logic                      fifo_empty,
   input  logic                      fifo_full,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      mismatch
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic          last_op_q, last_op_d;
   logic [CW-1:0] count_q, count_d;
   logic          mismatch_q, mismatch_d;

   logic          push_ok, pop_ok, sel_push, sel_pop, found;
   logic [PW-1:0] win_idx;
   logic [PW:0]   scan_sum;

   always_comb begin
      push_ok  = (|req_push) & ~fifo_full;
      pop_ok   = pop_req & ~fifo_empty;
      sel_push = push_ok & (~pop_ok | ~last_op_q);
      sel_pop  = pop_ok & (~push_ok | last_op_q);

      // Scan from rr_ptr upward, wrapping at NREQ (which need not be a power of two).
      found    = 1'b0;
      win_idx  = '0;
      scan_sum = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (scan_sum >= (PW+1)'(NREQ))
            scan_sum = scan_sum - (PW+1)'(NREQ);
         if (!found && req_push[scan_sum[PW-1:0]]) begin
            found   = 1'b1;
            win_idx = scan_sum[PW-1:0];
         end
      end

      grant_push = '0;
      fifo_in    = '0;
      fifo_push  = sel_push & reset_n;
      fifo_pop   = sel_pop & reset_n;
      pop_ack    = sel_pop & reset_n;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_push && reset_n && (PW'(i) == win_idx)) begin
            grant_push[i] = 1'b1;
            fifo_in       = req_data[i*WIDTH +: WIDTH];
         end
      end

      rr_ptr_d  = rr_ptr_q;
      last_op_d = last_op_q;
      count_d   = count_q;
      if (sel_push) begin
         rr_ptr_d  = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
         last_op_d = 1'b1;
         count_d   = count_q + CW'(1);
      end else if (sel_pop) begin
         last_op_d = 1'b0;
         count_d   = count_q - CW'(1);
      end

      mismatch_d = mismatch_q
                 | ((count_q == '0) != fifo_empty)
                 | ((count_q == CW'(DEPTH)) != fifo_full);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q   <= '0;
         last_op_q  <= 1'b0;
         count_q    <= '0;
         mismatch_q <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         last_op_q  <= last_op_d;
         count_q    <= count_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign count    = count_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler: the FIFO flags are driven from the
// bench's own expected occupancy so the scheduler sees a consistent FIFO.
module tb_fifo_access_scheduler;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int NREQ  = 4;

   logic                  clk;
   logic                  reset_n;
   logic [NREQ-1:0]       req_push;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       grant_push;
   logic                  pop_req;
   logic                  pop_ack;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [WIDTH-1:0]      fifo_in;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [4:0]            count;
   logic                  mismatch;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   fifo_access_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_push   (req_push),
      .req_data   (req_data),
      .grant_push (grant_push),
      .pop_req    (pop_req),
      .pop_ack    (pop_ack),
      .fifo_push  (fifo_push),
      .fifo_pop   (fifo_pop),
      .fifo_in    (fifo_in),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .count      (count),
      .mismatch   (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_flags();
      fifo_empty = (exp_cnt == 0);
      fifo_full  = (exp_cnt == DEPTH);
   endtask

   // Advance one clock, update the modelled FIFO flags, then let logic settle.
   task automatic step();
      @(posedge clk);
      #1;
      set_flags();
      #1;
   endtask

   task automatic do_reset();
      req_push = '0;
      pop_req  = 1'b0;
      exp_cnt  = 0;
      set_flags();
      reset_n  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      req_push = '0;
      req_data = '0;
      pop_req  = 1'b0;
      exp_cnt  = 0;
      set_flags();
      #12;

      // Reset state
      req_push = 4'b1111;
      chk("rst_grant", grant_push, 0);
      chk("rst_push", fifo_push, 0);
      chk("rst_count", count, 0);
      chk("rst_mismatch", mismatch, 0);
      do_reset();

      // Producer 2 pushes 0xA5
      req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
      req_push = 4'b0100;
      #1;
      chk("p2_grant", grant_push, 4'b0100);
      chk("p2_push", fifo_push, 1);
      chk("p2_data", fifo_in, 8'hA5);
      chk("p2_pop", fifo_pop, 0);
      exp_cnt = 1;
      step();
      req_push = 4'b0000;
      #1;
      chk("p2_count", count, 1);
      chk("p2_idle_grant", grant_push, 0);
      chk("p2_idle_push", fifo_push, 0);
      req_push = 4'b1111;
      #1;
      chk("p2_rr_ptr3", grant_push, 4'b1000);

      // All four producers, no pops, fill to DEPTH
      do_reset();
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req_push = 4'b1111;
      #1;
      for (int n = 0; n < DEPTH; n++) begin
         chk("fill_grant", grant_push, 4'b0001 << (n % 4));
         chk("fill_data", fifo_in, 8'h10 + 8'(n % 4));
         exp_cnt = n + 1;
         step();
      end
      chk("full_grant", grant_push, 0);
      chk("full_push", fifo_push, 0);
      chk("full_count", count, 16);
      step();
      chk("full_hold_count", count, 16);
      chk("full_mismatch", mismatch, 0);

      // Full with pop pending: pop served, push eligible the following cycle
      pop_req = 1'b1;
      #1;
      chk("full_pop_ack", pop_ack, 1);
      chk("full_pop_grant", grant_push, 0);
      exp_cnt = DEPTH - 1;
      step();
      chk("after_full_grant", grant_push, 4'b0001);
      chk("after_full_pop", fifo_pop, 0);

      // Pop-only into empty FIFO
      do_reset();
      pop_req = 1'b1;
      #1;
      for (int n = 0; n < 3; n++) begin
         chk("empty_pop_ack", pop_ack, 0);
         chk("empty_fifo_pop", fifo_pop, 0);
         step();
      end
      chk("empty_count", count, 0);
      chk("empty_mismatch", mismatch, 0);

      // Build 4 entries with last_op=0: five pushes then one pop
      do_reset();
      req_data = {8'h33, 8'h22, 8'h11, 8'h00};
      req_push = 4'b1000;
      for (int n = 0; n < 5; n++) begin
         exp_cnt = n + 1;
         step();
      end
      req_push = 4'b0000;
      pop_req  = 1'b1;
      #1;
      exp_cnt = 4;
      step();
      chk("alt_start_count", count, 4);

      // Producer 1 and consumer contend: push, pop, push, pop
      req_push = 4'b0010;
      #1;
      for (int n = 0; n < 4; n++) begin
         if (n % 2 == 0) begin
            chk("alt_grant", grant_push, 4'b0010);
            chk("alt_push", fifo_push, 1);
            chk("alt_pop", fifo_pop, 0);
            chk("alt_data", fifo_in, 8'h11);
            exp_cnt = 5;
         end else begin
            chk("alt_grant", grant_push, 0);
            chk("alt_push", fifo_push, 0);
            chk("alt_pop_ack", pop_ack, 1);
            exp_cnt = 4;
         end
         chk("alt_exclusive", fifo_push & fifo_pop, 0);
         step();
         chk("alt_count", count, exp_cnt);
      end
      chk("alt_mismatch", mismatch, 0);

      // Flag disagreement is sticky until reset
      do_reset();
      fifo_empty = 1'b0;
      @(posedge clk);
      #1;
      fifo_empty = 1'b1;
      #1;
      chk("mm_set", mismatch, 1);
      step();
      step();
      chk("mm_held", mismatch, 1);
      do_reset();
      chk("mm_cleared", mismatch, 0);

      // Reset mid-stream with grant active
      req_data = {8'h44, 8'h33, 8'h22, 8'h77};
      req_push = 4'b0001;
      #1;
      exp_cnt = 1;
      step();
      exp_cnt = 2;
      step();
      chk("mid_count", count, 2);
      chk("mid_grant", grant_push, 4'b0001);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_grant", grant_push, 0);
      chk("mid_rst_push", fifo_push, 0);
      chk("mid_rst_data", fifo_in, 0);
      chk("mid_rst_count", count, 0);
      exp_cnt = 0;
      set_flags();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("post_rst_count", count, 0);
      // Contention right after reset: push wins, rr_ptr back at producer 0
      req_push   = 4'b1111;
      pop_req    = 1'b1;
      fifo_empty = 1'b0;
      #1;
      chk("post_rst_grant", grant_push, 4'b0001);
      chk("post_rst_pop", pop_ack, 0);
      chk("post_rst_data", fifo_in, 8'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
